// File: rtl/rs_branch_if.sv
// Shared micro-op payload type and the dispatch/wakeup/issue bundle of the branch reservation station.
package rs_branch_pkg;
  localparam int unsigned RS_ROB_W  = 5;
  localparam int unsigned RS_PREG_W = 7;

  typedef struct packed {
    logic [6:0]           opcode;
    logic [2:0]           func3;
    logic [31:0]          pc;
    logic [31:0]          imm;
    logic [RS_PREG_W-1:0] pd;
    logic [RS_PREG_W-1:0] ps1;
    logic [RS_PREG_W-1:0] ps2;
    logic                 ps1_ready;
    logic                 ps2_ready;
    logic [RS_ROB_W-1:0]  rob_index;
  } rs_data_t;
endpackage

interface rs_branch_if #(
  parameter int unsigned DEPTH = 8
);
  import rs_branch_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                 disp_valid;
  rs_data_t             disp_data;
  logic                 full;
  logic                 cdb_valid;
  logic [RS_PREG_W-1:0] cdb_tag;
  logic                 fu_b_ready;
  logic [RS_ROB_W-1:0]  rob_head;
  logic                 mispredict;
  logic [RS_ROB_W-1:0]  mispredict_tag;
  logic                 issued;
  rs_data_t             data_out;
  logic [CNT_W-1:0]     count;

  modport master (
    output disp_valid, disp_data, cdb_valid, cdb_tag, fu_b_ready,
           rob_head, mispredict, mispredict_tag,
    input  full, issued, data_out, count
  );

  modport slave (
    input  disp_valid, disp_data, cdb_valid, cdb_tag, fu_b_ready,
           rob_head, mispredict, mispredict_tag,
    output full, issued, data_out, count
  );
endinterface

// File: rtl/rs_branch.sv
// Branch reservation station: buffers dispatched ops, wakes operands from the CDB,
// issues the oldest ready entry by ROB age and squashes younger entries on mispredict.
module rs_branch
  import rs_branch_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ROB_W  = RS_ROB_W,
  parameter int unsigned PREG_W = RS_PREG_W
) (
  input logic        clk,
  input logic        reset,
  rs_branch_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  rs_data_t         ent_q [DEPTH];
  logic [DEPTH-1:0] valid_q, rdy1_q, rdy2_q;
  logic [DEPTH-1:0] valid_d, rdy1_d, rdy2_d;
  logic [ROB_W-1:0] age   [DEPTH];
  logic [ROB_W-1:0] mp_age;
  logic [ROB_W-1:0] sel_age;
  logic [IDX_W-1:0] free_idx, sel_idx;
  logic             sel_found;
  logic             disp_en, issue_en;
  logic             disp_rdy1, disp_rdy2;
  logic [CNT_W-1:0] cnt_d;

  assign bus.full = &valid_q;
  assign mp_age   = ROB_W'(bus.mispredict_tag - bus.rob_head);
  assign disp_en  = bus.disp_valid && !bus.full && !bus.mispredict;
  assign issue_en = bus.fu_b_ready && sel_found && !bus.mispredict;

  assign disp_rdy1 = bus.disp_data.ps1_ready |
                     (bus.cdb_valid && (PREG_W'(bus.cdb_tag) == PREG_W'(bus.disp_data.ps1)));
  assign disp_rdy2 = bus.disp_data.ps2_ready |
                     (bus.cdb_valid && (PREG_W'(bus.cdb_tag) == PREG_W'(bus.disp_data.ps2)));

  // Age relative to the ROB head makes index wrap-around order correctly.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      age[i] = ROB_W'(ent_q[i].rob_index - bus.rob_head);
    end
  end

  // Lowest free slot for dispatch, and the oldest fully-ready entry for issue.
  always_comb begin
    free_idx  = '0;
    sel_idx   = '0;
    sel_age   = '1;
    sel_found = 1'b0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid_q[i] && rdy1_q[i] && rdy2_q[i] && (!sel_found || age[i] < sel_age)) begin
        sel_idx   = IDX_W'(i);
        sel_age   = age[i];
        sel_found = 1'b1;
      end
    end
  end

  // Next entry state: wakeup, flush, issue, then dispatch into a slot that was free.
  always_comb begin
    valid_d = valid_q;
    rdy1_d  = rdy1_q;
    rdy2_d  = rdy2_q;
    cnt_d   = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (bus.cdb_valid && (PREG_W'(ent_q[i].ps1) == PREG_W'(bus.cdb_tag))) rdy1_d[i] = 1'b1;
      if (bus.cdb_valid && (PREG_W'(ent_q[i].ps2) == PREG_W'(bus.cdb_tag))) rdy2_d[i] = 1'b1;
      if (bus.mispredict && valid_q[i] && (age[i] > mp_age)) valid_d[i] = 1'b0;
    end
    if (issue_en) valid_d[sel_idx] = 1'b0;
    if (disp_en) begin
      valid_d[free_idx] = 1'b1;
      rdy1_d[free_idx]  = disp_rdy1;
      rdy2_d[free_idx]  = disp_rdy2;
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      cnt_d = cnt_d + CNT_W'(valid_d[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q      <= '0;
      rdy1_q       <= '0;
      rdy2_q       <= '0;
      bus.issued   <= 1'b0;
      bus.data_out <= '0;
      bus.count    <= '0;
    end else begin
      valid_q    <= valid_d;
      rdy1_q     <= rdy1_d;
      rdy2_q     <= rdy2_d;
      bus.issued <= issue_en;
      bus.count  <= cnt_d;
      if (issue_en) bus.data_out <= ent_q[sel_idx];
    end
  end

  // Payload storage is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (disp_en) ent_q[free_idx] <= bus.disp_data;
  end

endmodule

// File: doc/rs_branch.md
# rs_branch

Reservation station for the branch functional unit. It buffers dispatched JALR/BNE micro-ops and tracks source-operand readiness through CDB wakeup. Each cycle it issues the oldest ready entry (by ROB age) to fu_branch, which it feeds directly. On a branch mispredict it squashes every entry younger than the mispredicting branch.

## Interface
Parameters:
- DEPTH, 8, number of entries (power of two, 2..16)
- ROB_W, 5, ROB index width (32-entry ROB)
- PREG_W, 7, physical register tag width

Ports:
- clk  in  1  clock, all state on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- disp_valid  in  1  dispatch request this cycle
- disp_data  in  rs_data  dispatched micro-op; fields used: Opcode[6:0], func3[2:0], pc[31:0], imm[31:0], pd[PREG_W-1:0], ps1/ps2[PREG_W-1:0], ps1_ready, ps2_ready, rob_index[ROB_W-1:0]
- full  out  1  all DEPTH entries valid (combinational from valid bits)
- cdb_valid  in  1  result broadcast valid
- cdb_tag  in  PREG_W  physical register being woken
- fu_b_ready  in  1  fu_branch can accept an op this cycle
- rob_head  in  ROB_W  index of oldest in-flight ROB entry (age base)
- mispredict  in  1  flush request from fu_branch
- mispredict_tag  in  ROB_W  ROB index of mispredicting branch
- issued  out  1  registered one-cycle pulse: data_out valid for fu_branch
- data_out  out  rs_data  registered issued micro-op
- count  out  $clog2(DEPTH)+1  number of valid entries

## Operation
- Entry state: valid, payload, rdy1, rdy2.
- Age: age(x) = (x − rob_head) mod 2^ROB_W. Smaller age means older. All age comparisons use this, so ROB index wrap-around is handled.
- Dispatch:
  - If disp_valid && !full && !mispredict, write to the lowest-index free entry.
  - rdy1 = ps1_ready | (cdb_valid && cdb_tag == ps1). rdy2 is computed the same way from ps2_ready and ps2.
  - If disp_valid && full, the request is dropped. Upstream must not do this; the bench flags it as an error.
- Wakeup: each valid entry with ps1 == cdb_tag sets rdy1 when cdb_valid. rdy2 is set the same way for ps2.
- Select:
  - Candidates are valid entries with rdy1 && rdy2 that were not written this cycle.
  - Pick the candidate with minimum age. Ties are impossible because ROB indices are unique.
- Issue:
  - Occurs if fu_b_ready && a candidate exists && !mispredict.
  - At the edge: data_out <= selected payload, issued <= 1, the entry is invalidated.
  - Otherwise issued <= 0 and data_out holds its previous value.
- Flush: when mispredict is asserted, invalidate every valid entry with age(rob_index) > age(mispredict_tag).
  - Older and equal entries are retained.
  - No issue occurs that cycle.
  - Any dispatch that cycle is dropped.
- Dispatch and issue in the same cycle are allowed when not full. A full RS that issues still rejects same-cycle dispatch (full is computed before issue).
- count is the registered number of valid entries after each edge.

## Timing
- Reset (async assert): all valid = 0, issued = 0, data_out = '0, count = 0, full = 0.
- Reset deassert mid-operation discards all entries. No issue occurs until the first post-reset dispatch.
- Minimum latency:
  - Dispatch with both operands ready at edge N gives issued = 1 after edge N+1.
  - fu_branch samples data_out at edge N+2.
- Wakeup latency: a CDB broadcast at edge N makes the entry eligible in cycle N+1; issued is high after edge N+1.
- A CDB tag that matches a same-cycle dispatch is captured and is not lost.
- issued is high for exactly one cycle per issued op. Back-to-back issue on consecutive cycles is allowed.
- Mispredict takes effect at the same edge it is sampled. Surviving entries may issue from the following cycle.

## Test plan
- Reset: assert reset mid-cycle with 3 entries valid -> immediately issued = 0, count = 0, full = 0, data_out = 0.
- Basic issue: dispatch BNE, rob_index = 12, pc = 2000, both ready, fu_b_ready = 1 -> issued = 1 one cycle after the dispatch edge, data_out.rob_index = 12, pc = 2000, count back to 0.
- Wakeup and age:
  - Setup: rob_head = 30. Dispatch A (rob 31, ps1 = 9 not ready), then B (rob 2, ready).
  - Expected: B issues first.
  - Then broadcast cdb_tag = 9 -> A issues next cycle.
  - Checks wrap-around age ordering.
- Same-cycle wakeup: dispatch with ps2 = 17 not ready while cdb_valid, cdb_tag = 17 -> entry issues on the next cycle.
- Flush:
  - Setup: rob_head = 0. Entries rob 3, 5, 8, 10 pending, not ready.
  - Apply mispredict with mispredict_tag = 5 -> rob 8 and 10 invalidated, count = 2, no issue that cycle.
  - A simultaneous dispatch is dropped.
- Full/backpressure:
  - Fill DEPTH = 8 entries with fu_b_ready = 0 -> full = 1, and a further dispatch is ignored (count stays 8).
  - Raise fu_b_ready -> one issue per cycle, oldest first, full drops after the first issue.
